// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the D-stage hazard controller: stage indices,
// Tuse/Tnew "unused" code, MDU op selects and default latencies.
package hazard_ctrl_pkg;
    localparam int DEF_NSTAGE  = 3;
    localparam int DEF_TW      = 3;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    // Forward-select encoding: 0 = register file, k = pipeline stage k.
    localparam int SEL_RF = 0;
    localparam int SEL_E  = 1;
    localparam int SEL_M  = 2;
    localparam int SEL_W  = 3;

    typedef enum logic {
        MDU_OP_MUL = 1'b0,
        MDU_OP_DIV = 1'b1
    } mdu_op_e;

    // All-ones Tuse/Tnew code marks a source/result that is not used.
    function automatic int t_none(input int tw);
        return (1 << tw) - 1;
    endfunction

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage decode info in, stall / forward selects / MDU busy out.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int TW   = DEF_TW,
    parameter int SELW = $clog2(DEF_NSTAGE + 1)
);
    logic            d_valid;
    logic [4:0]      d_rs;
    logic [4:0]      d_rt;
    logic [TW-1:0]   d_rsT;
    logic [TW-1:0]   d_rtT;
    logic            d_we;
    logic [4:0]      d_wa;
    logic [TW-1:0]   d_tnew;
    logic            d_mdu_start;
    logic            d_mdu_div;
    logic            d_mdu_use;
    logic            stall;
    logic [SELW-1:0] fwd_rs_sel;
    logic [SELW-1:0] fwd_rt_sel;
    logic            mdu_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_rsT, d_rtT, d_we, d_wa, d_tnew,
               d_mdu_start, d_mdu_div, d_mdu_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rsT, d_rtT, d_we, d_wa, d_tnew,
               d_mdu_start, d_mdu_div, d_mdu_use,
        output stall, fwd_rs_sel, fwd_rt_sel, mdu_busy
    );
endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// Multiply/divide busy timer: loads the op latency on an accepted start
// and counts down to idle.
module mdu_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_start,
    input  mdu_op_e i_op,
    output logic    o_busy
);
    localparam int CW = $clog2(lat_max(MUL_LAT, DIV_LAT) + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_start)
            r_cnt <= (i_op == MDU_OP_DIV) ? CW'(DIV_LAT) : CW'(MUL_LAT);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Tnew/Tuse scoreboard for stages after D: raises stall, picks the youngest
// forwarding source per operand, and gates MDU ops on the busy timer.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE  = DEF_NSTAGE,
    parameter int TW      = DEF_TW,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    localparam int            SELW   = $clog2(NSTAGE + 1);
    localparam logic [TW-1:0] T_NONE = TW'(t_none(TW));

    typedef struct packed {
        logic          v;
        logic          we;
        logic [4:0]    wa;
        logic [TW-1:0] tnew;
    } sb_t;

    logic                       w_stall;
    logic                       w_busy;
    logic [NSTAGE:1]            w_m_rs;
    logic [NSTAGE:1]            w_m_rt;
    logic [NSTAGE:1][TW-1:0]    w_tn;
    logic [SELW-1:0]            w_rs_sel, w_rt_sel;
    logic [TW-1:0]              w_rs_tn, w_rt_tn;
    logic                       w_rs_hz, w_rt_hz, w_mdu_hz;

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_stg
        sb_t r_ent;
        sb_t w_nxt;

        if (k == 1) begin : g_head
            // A stalled or empty D slot enters E as a bubble.
            always_comb begin
                w_nxt      = '0;
                w_nxt.v    = bus.d_valid && !w_stall;
                w_nxt.we   = bus.d_we;
                w_nxt.wa   = bus.d_wa;
                w_nxt.tnew = bus.d_tnew;
            end
        end else begin : g_tail
            always_comb begin
                w_nxt = g_stg[k-1].r_ent;
                if (g_stg[k-1].r_ent.tnew != '0)
                    w_nxt.tnew = g_stg[k-1].r_ent.tnew - 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_ent <= '0;
            else       r_ent <= w_nxt;
        end

        assign w_m_rs[k] = r_ent.v && r_ent.we && (r_ent.wa == bus.d_rs) && (bus.d_rs != 5'd0);
        assign w_m_rt[k] = r_ent.v && r_ent.we && (r_ent.wa == bus.d_rt) && (bus.d_rt != 5'd0);
        assign w_tn[k]   = r_ent.tnew;
    end

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        w_rs_sel = '0;
        w_rt_sel = '0;
        w_rs_tn  = '0;
        w_rt_tn  = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (w_m_rs[k]) begin
                w_rs_sel = SELW'(k);
                w_rs_tn  = w_tn[k];
            end
            if (w_m_rt[k]) begin
                w_rt_sel = SELW'(k);
                w_rt_tn  = w_tn[k];
            end
        end
    end

    assign w_rs_hz  = (bus.d_rsT != T_NONE) && (w_rs_sel != '0) && (w_rs_tn > bus.d_rsT);
    assign w_rt_hz  = (bus.d_rtT != T_NONE) && (w_rt_sel != '0) && (w_rt_tn > bus.d_rtT);
    assign w_mdu_hz = (bus.d_mdu_start || bus.d_mdu_use) && w_busy;
    assign w_stall  = bus.d_valid && (w_rs_hz || w_rt_hz || w_mdu_hz);

    mdu_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_timer (
        .clk     (clk),
        .reset   (reset),
        .i_start (bus.d_valid && bus.d_mdu_start && !w_stall),
        .i_op    (mdu_op_e'(bus.d_mdu_div)),
        .o_busy  (w_busy)
    );

    assign bus.stall      = w_stall;
    assign bus.fwd_rs_sel = w_rs_sel;
    assign bus.fwd_rt_sel = w_rt_sel;
    assign bus.mdu_busy   = w_busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, youngest-wins, $0,
// tnew saturation, bubbles, MDU timing and reset mid-divide.
module tb_hazard_ctrl;
    localparam logic [2:0] N = 3'b111;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    hazard_ctrl_if #(.TW(3), .SELW(2)) bus ();

    hazard_ctrl #(
        .NSTAGE  (3),
        .TW      (3),
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [2:0] rsT,
                         input logic [4:0] rt, input logic [2:0] rtT,
                         input logic we, input logic [4:0] wa, input logic [2:0] tn,
                         input logic ms, input logic md, input logic mu);
        bus.d_valid     = v;
        bus.d_rs        = rs;
        bus.d_rsT       = rsT;
        bus.d_rt        = rt;
        bus.d_rtT       = rtT;
        bus.d_we        = we;
        bus.d_wa        = wa;
        bus.d_tnew      = tn;
        bus.d_mdu_start = ms;
        bus.d_mdu_div   = md;
        bus.d_mdu_use   = mu;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        set_d(0, 0, N, 0, N, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;

        // reset holds everything quiet even with a live D instruction
        set_d(1, 8, 0, 8, 0, 1, 8, 3, 1, 1, 1);
        chk("rst_stall", bus.stall, 0);
        chk("rst_busy", bus.mdu_busy, 0);
        chk("rst_fwd_rs", bus.fwd_rs_sel, 0);
        chk("rst_fwd_rt", bus.fwd_rt_sel, 0);
        step();
        chk("rst_hold_busy", bus.mdu_busy, 0);
        chk("rst_hold_fwd", bus.fwd_rs_sel, 0);
        reset = 1'b0;
        flush();

        // load-use: lw $8 tnew=2, then add rs=$8 rsT=1
        set_d(1, 0, N, 0, N, 1, 8, 2, 0, 0, 0);
        chk("lu_lw_stall", bus.stall, 0);
        step();
        set_d(1, 8, 1, 0, N, 1, 10, 1, 0, 0, 0);
        chk("lu_stall", bus.stall, 1);
        chk("lu_fwd_e", bus.fwd_rs_sel, 1);
        step();
        chk("lu_stall2", bus.stall, 0);
        chk("lu_fwd_m", bus.fwd_rs_sel, 2);
        step();
        flush();

        // branch after ALU op: add $9 tnew=1, beq rs=$9 rsT=0, rt=$9 rtT=1
        set_d(1, 0, N, 0, N, 1, 9, 1, 0, 0, 0);
        step();
        set_d(1, 9, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        chk("br_stall", bus.stall, 1);
        chk("br_fwd_rs", bus.fwd_rs_sel, 1);
        chk("br_fwd_rt", bus.fwd_rt_sel, 1);
        step();
        chk("br_stall2", bus.stall, 0);
        chk("br_fwd_rs2", bus.fwd_rs_sel, 2);
        step();
        flush();

        // youngest wins: older $5 still has tnew=2, youngest $5 tnew=0
        set_d(1, 0, N, 0, N, 1, 5, 4, 0, 0, 0);
        step();
        set_d(1, 0, N, 0, N, 0, 0, 0, 0, 0, 0);
        step();
        set_d(1, 0, N, 0, N, 1, 5, 0, 0, 0, 0);
        step();
        set_d(1, 5, 0, 5, N, 0, 0, 0, 0, 0, 0);
        chk("yw_fwd_rs", bus.fwd_rs_sel, 1);
        chk("yw_fwd_rt", bus.fwd_rt_sel, 1);
        chk("yw_stall", bus.stall, 0);
        flush();

        // tnew saturates at 0 instead of wrapping to all-ones
        set_d(1, 0, N, 0, N, 1, 6, 1, 0, 0, 0);
        step();
        set_d(0, 0, N, 0, N, 0, 0, 0, 0, 0, 0);
        step();
        step();
        set_d(1, 6, 0, 0, N, 0, 0, 0, 0, 0, 0);
        chk("sat_stall", bus.stall, 0);
        chk("sat_fwd_w", bus.fwd_rs_sel, 3);
        flush();

        // register zero never matches
        set_d(1, 0, N, 0, N, 1, 0, 3, 0, 0, 0);
        step();
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("z_stall", bus.stall, 0);
        chk("z_fwd_rs", bus.fwd_rs_sel, 0);
        chk("z_fwd_rt", bus.fwd_rt_sel, 0);
        flush();

        // d_valid=0: no stall, and a bubble enters stage 1
        set_d(1, 0, N, 0, N, 1, 8, 3, 0, 0, 0);
        step();
        set_d(0, 8, 0, 0, N, 0, 0, 0, 0, 0, 0);
        chk("nv_stall", bus.stall, 0);
        chk("nv_fwd", bus.fwd_rs_sel, 1);
        step();
        set_d(1, 8, 0, 0, N, 0, 0, 0, 0, 0, 0);
        chk("nv_bubble_fwd", bus.fwd_rs_sel, 2);
        chk("nv_stall2", bus.stall, 1);
        flush();

        // MDU: div at cycle 0, mflo stalls cycles 1..10
        set_d(1, 0, N, 0, N, 0, 0, 0, 1, 1, 0);
        chk("div_acc_stall", bus.stall, 0);
        chk("div_acc_busy", bus.mdu_busy, 0);
        step();
        for (int c = 1; c <= 10; c++) begin
            set_d(1, 0, N, 0, N, 1, 2, 0, 0, 0, 1);
            chk($sformatf("div_stall_c%0d", c), bus.stall, 1);
            chk($sformatf("div_busy_c%0d", c), bus.mdu_busy, 1);
            step();
        end
        set_d(1, 0, N, 0, N, 1, 2, 0, 0, 0, 1);
        chk("div_stall_c11", bus.stall, 0);
        chk("div_busy_c11", bus.mdu_busy, 0);
        step();
        set_d(1, 0, N, 0, N, 0, 0, 0, 1, 0, 0);
        chk("mul_acc_stall", bus.stall, 0);
        step();
        set_d(1, 0, N, 0, N, 0, 0, 0, 1, 0, 0);
        chk("mul_restart_stall", bus.stall, 1);
        chk("mul_busy_c1", bus.mdu_busy, 1);
        step();
        for (int c = 2; c <= 5; c++) begin
            set_d(0, 0, N, 0, N, 0, 0, 0, 0, 0, 0);
            chk($sformatf("mul_busy_c%0d", c), bus.mdu_busy, 1);
            step();
        end
        chk("mul_busy_done", bus.mdu_busy, 0);
        flush();

        // reset in the middle of a divide
        set_d(1, 0, N, 0, N, 0, 0, 0, 1, 1, 0);
        step();
        set_d(0, 0, N, 0, N, 0, 0, 0, 0, 0, 0);
        step();
        step();
        set_d(1, 0, N, 0, N, 1, 4, 0, 0, 0, 0);
        step();
        set_d(1, 4, 0, 0, N, 1, 2, 0, 0, 0, 1);
        chk("pre_rst_stall", bus.stall, 1);
        chk("pre_rst_fwd", bus.fwd_rs_sel, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", bus.mdu_busy, 0);
        chk("mid_rst_stall", bus.stall, 0);
        chk("mid_rst_fwd", bus.fwd_rs_sel, 0);
        step();
        reset = 1'b0;
        set_d(1, 0, N, 0, N, 0, 0, 0, 1, 1, 0);
        chk("post_rst_stall", bus.stall, 0);
        step();
        chk("post_rst_busy", bus.mdu_busy, 1);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NSTAGE, default 3, number of tracked stages after D (1=E, 2=M, 3=W).
REQ-002 Parameter TW, default 3, width of Tnew/Tuse codes; all-ones means "not used".
REQ-003 Parameter MUL_LAT, default 5, MDU busy cycles for mult/multu.
REQ-004 Parameter DIV_LAT, default 10, MDU busy cycles for div/divu.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 d_valid  in  1  D stage holds a real instruction.
REQ-008 d_rs, d_rt  in  5 each  D source register numbers.
REQ-009 d_rsT, d_rtT  in  TW each  Tuse per source (cycles until value is consumed); all-ones means the source is unused.
REQ-010 d_we  in  1  D instruction writes the register file.
REQ-011 d_wa  in  5  D destination register.
REQ-012 d_tnew  in  TW  cycles after entering E until the result is produced.
REQ-013 d_mdu_start  in  1  D is mult/multu/div/divu.
REQ-014 d_mdu_div  in  1  qualifies d_mdu_start as div/divu.
REQ-015 d_mdu_use  in  1  D is mfhi/mflo/mthi/mtlo.
REQ-016 stall  out  1  freeze F/D and insert a bubble into E.
REQ-017 fwd_rs_sel, fwd_rt_sel  out  $clog2(NSTAGE+1) each  0 = register file; k = youngest stage k holding the matching destination.
REQ-018 mdu_busy  out  1  MDU counter nonzero.

Function
REQ-019 Scoreboard: per stage k = 1..NSTAGE, the block SHALL hold {v, we, wa, tnew}.
REQ-020 Each edge with stall=0: the D entry {d_valid, d_we, d_wa, d_tnew} SHALL load stage 1, and stage k SHALL load stage k-1 with tnew decremented, saturating at 0. The oldest entry is discarded.
REQ-021 Each edge with stall=1: stage 1 SHALL load a bubble (v=0); stages 2..NSTAGE SHALL advance as in REQ-020.
REQ-022 Match(k, r) SHALL be v && we && wa==r && r!=0; register 0 SHALL never match.
REQ-023 Source r with Tuse u (u not all-ones) SHALL raise a data stall if the youngest matching stage has tnew > u; older matches SHALL be ignored.
REQ-024 fwd_*_sel SHALL be the index of the youngest matching stage, else 0. The output is combinational and independent of tnew and stall.
REQ-025 MDU counter: on an edge with d_valid && d_mdu_start && !stall, the counter SHALL load DIV_LAT if d_mdu_div, else MUL_LAT. Otherwise, if nonzero, it SHALL decrement by 1.
REQ-026 mdu_busy SHALL equal (counter != 0). It is registered-derived, so it rises the cycle after the start is accepted.
REQ-027 MDU stall SHALL be d_valid && (d_mdu_start || d_mdu_use) && mdu_busy.
REQ-028 stall SHALL be d_valid && (rs data stall || rt data stall || MDU stall). It is combinational, with no added latency.
REQ-029 With d_valid=0, stall SHALL be 0 and a bubble SHALL enter stage 1.
REQ-030 Counter width SHALL be $clog2(max(MUL_LAT, DIV_LAT)+1). MUL_LAT and DIV_LAT SHALL each be ≥1.

Reset
REQ-031 Asserting reset SHALL immediately clear all v bits and the MDU counter, including mid-MDU operation.
REQ-032 While reset is asserted: stall=0, mdu_busy=0, fwd_rs_sel=fwd_rt_sel=0.
REQ-033 The first edge after deassertion SHALL behave as a normal edge.

Structure
REQ-034 The Tuse/Tnew "unused" code (all-ones), the stage index encoding, and the default latencies SHALL live in the shared macros/package alongside the decoder encodings.
REQ-035 One sub-module, mdu_timer (counter, load and busy logic), SHALL be instantiated.
REQ-036 The scoreboard SHALL be generated over NSTAGE; no per-stage hand-written code.

Verification
REQ-037 Load-use: lw $8 (tnew=2) in E, D add rs=$8 (rsT=1) -> stall=1 for 1 cycle, then fwd_rs_sel=2.
REQ-038 Branch after ALU op: add $9 (tnew=1) in E, D beq rs=$9 (rsT=0) -> stall=1 for 1 cycle, then stall=0 with fwd_rs_sel=2.
REQ-039 Youngest wins: $5 written in stage 3 (tnew 0) and stage 1 (tnew 0), D uses $5 -> fwd_rs_sel=1, stall=0.
REQ-040 Register zero: stage 1 writes $0 with tnew=3, D uses $0 (rsT=0) -> stall=0, fwd_rs_sel=0.
REQ-041 MDU: div accepted at cycle 0 (DIV_LAT=10), mflo in D from cycle 1 -> stall=1 for cycles 1..10, 0 at cycle 11; mult accepted after -> mdu_busy high for 5 cycles.
REQ-042 Reset mid-div at cycle 4 -> mdu_busy=0 and stall=0 immediately; scoreboard empty, so fwd selects = 0.
